// File: rtl/fpu_seq.sv
// Multi-cycle IEEE-754-style add/sub/mul unit with start/done handshake.
// Round-to-nearest-even, subnormal flush-to-zero, {overflow, underflow, inexact} flags.
module fpu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [EXP_W+MAN_W:0]     in_a,
   input  logic [EXP_W+MAN_W:0]     in_b,
   output logic [EXP_W+MAN_W:0]     out,
   output logic                     done,
   output logic                     busy,
   output logic [2:0]               flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int N  = MAN_W + 1;          // significand width incl. hidden bit
   localparam int F  = MAN_W + 4;          // hidden, fraction, G, R, S
   localparam int M  = MAN_W + 5;          // carry + F
   localparam int XW = EXP_W + 2;
   localparam int CW = $clog2(N + 1);
   localparam logic [EXP_W-1:0]    EXP_ONES = '1;
   localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ARITH, NORM, ROUND, CHECK, DONE} state_t;

   state_t                 state;
   logic [W-1:0]           a_reg, b_reg, res_reg;
   logic [1:0]             op_reg;
   logic                   special_reg, sign_reg, eff_sub_reg, inexact_reg;
   logic signed [XW-1:0]   exp_reg;
   logic [F-1:0]           sig_a_reg, sig_b_reg;
   logic [M-1:0]           man_reg;
   logic [2*N-1:0]         prod_reg;
   logic [N-1:0]           mcand_reg;
   logic [CW-1:0]          cnt_reg;

   logic                   sa, sb, sb_eff, is_mul, swap, spec;
   logic [EXP_W-1:0]       ea, eb, e_big, e_small, d;
   logic [MAN_W-1:0]       fa, fb;
   logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [F-1:0]           big_f, small_f, lost_mask, shifted;
   logic [W-1:0]           spec_res;
   logic signed [XW-1:0]   mul_exp;

   // Unpack, special-value resolution and alignment of the captured operands
   always_comb begin
      {sa, ea, fa} = a_reg;
      {sb, eb, fb} = b_reg;
      is_mul  = (op_reg == 2'b10);
      sb_eff  = sb ^ (op_reg == 2'b01);
      a_nan   = (ea == EXP_ONES) && (fa != '0);
      b_nan   = (eb == EXP_ONES) && (fb != '0);
      a_inf   = (ea == EXP_ONES) && (fa == '0);
      b_inf   = (eb == EXP_ONES) && (fb == '0);
      a_zero  = (ea == '0);
      b_zero  = (eb == '0);
      spec     = 1'b1;
      spec_res = '0;
      if (a_nan || b_nan)
         spec_res = QNAN;
      else if (is_mul) begin
         if ((a_inf && b_zero) || (a_zero && b_inf)) spec_res = QNAN;
         else if (a_inf || b_inf)   spec_res = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
         else if (a_zero || b_zero) spec_res = {sa ^ sb, {(W-1){1'b0}}};
         else                       spec = 1'b0;
      end else begin
         if (a_inf && b_inf)        spec_res = (sa != sb_eff) ? QNAN : {sa, EXP_ONES, {MAN_W{1'b0}}};
         else if (a_inf)            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
         else if (b_inf)            spec_res = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
         else if (a_zero && b_zero) spec_res = {sa & sb_eff, {(W-1){1'b0}}};
         else if (a_zero)           spec_res = {sb_eff, eb, fb};
         else if (b_zero)           spec_res = a_reg;
         else                       spec = 1'b0;
      end
      swap    = ({eb, fb} > {ea, fa});
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      big_f   = {1'b1, swap ? fb : fa, 3'b000};
      small_f = {1'b1, swap ? fa : fb, 3'b000};
      d       = e_big - e_small;
      lost_mask = '0;
      if (d >= EXP_W'(F - 1))
         shifted = {{(F-1){1'b0}}, 1'b1};
      else begin
         lost_mask = (F'(1) << d) - F'(1);
         shifted   = (small_f >> d) | {{(F-1){1'b0}}, |(small_f & lost_mask)};
      end
      mul_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
   end

   logic [N:0]           psum;
   logic [2*N-1:0]       prod_next;
   logic                 round_up;
   logic signed [XW-1:0] e_c;
   logic [MAN_W-1:0]     frac_c;

   always_comb begin
      psum      = {1'b0, prod_reg[2*N-1:N]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
      prod_next = {psum, prod_reg[N-1:1]};
      round_up  = man_reg[2] & (man_reg[1] | man_reg[0] | man_reg[3]);
      e_c       = exp_reg + (man_reg[M-1] ? XW'(1) : XW'(0));
      frac_c    = man_reg[M-1] ? man_reg[M-2:4] : man_reg[M-3:3];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;  out <= '0;  done <= 1'b0;  busy <= 1'b0;  flags <= '0;
         a_reg <= '0;  b_reg <= '0;  res_reg <= '0;  op_reg <= '0;
         special_reg <= 1'b0;  sign_reg <= 1'b0;  eff_sub_reg <= 1'b0;  inexact_reg <= 1'b0;
         exp_reg <= '0;  sig_a_reg <= '0;  sig_b_reg <= '0;  man_reg <= '0;
         prod_reg <= '0;  mcand_reg <= '0;  cnt_reg <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_reg <= in_a;  b_reg <= in_b;  op_reg <= op;
               busy  <= 1'b1;  inexact_reg <= 1'b0;
               state <= ALIGN;
            end
            ALIGN: begin
               special_reg <= spec;
               res_reg     <= spec_res;
               sign_reg    <= is_mul ? (sa ^ sb) : (swap ? sb_eff : sa);
               exp_reg     <= is_mul ? mul_exp : $signed({2'b00, e_big});
               sig_a_reg   <= big_f;
               sig_b_reg   <= shifted;
               eff_sub_reg <= sa ^ sb_eff;
               mcand_reg   <= {1'b1, fa};
               prod_reg    <= {{N{1'b0}}, 1'b1, fb};
               cnt_reg     <= '0;
               state       <= ARITH;
            end
            ARITH: begin
               if (special_reg) begin
                  out <= res_reg;  flags <= '0;  done <= 1'b1;  state <= DONE;
               end else if (is_mul) begin
                  prod_reg <= prod_next;
                  cnt_reg  <= cnt_reg + 1'b1;
                  // Product bits below R fold into sticky
                  if (cnt_reg == CW'(N - 1)) begin
                     man_reg <= {prod_next[2*N-1:2*N-M+1], |prod_next[2*N-M:0]};
                     state   <= NORM;
                  end
               end else begin
                  man_reg <= eff_sub_reg ? ({1'b0, sig_a_reg} - {1'b0, sig_b_reg})
                                         : ({1'b0, sig_a_reg} + {1'b0, sig_b_reg});
                  state   <= NORM;
               end
            end
            NORM: begin
               if (man_reg == '0) begin
                  out <= '0;  flags <= '0;  done <= 1'b1;  state <= DONE;
               end else if (man_reg[M-1]) begin
                  man_reg <= {1'b0, man_reg[M-1:2], man_reg[1] | man_reg[0]};
                  exp_reg <= exp_reg + XW'(1);
               end else if (man_reg[M-2]) begin
                  state <= ROUND;
               end else begin
                  // The last left shift exits directly once the next bit becomes the hidden bit
                  man_reg <= man_reg << 1;
                  exp_reg <= exp_reg - XW'(1);
                  if (man_reg[M-3]) state <= ROUND;
               end
            end
            ROUND: begin
               man_reg     <= {man_reg[M-1:3] + (M-3)'(round_up), 3'b000};
               inexact_reg <= |man_reg[2:0];
               state       <= CHECK;
            end
            CHECK: begin
               if (e_c >= EXP_MAX) begin
                  out <= {sign_reg, EXP_ONES, {MAN_W{1'b0}}};  flags <= 3'b101;
               end else if (e_c <= 0) begin
                  out <= {sign_reg, {(W-1){1'b0}}};  flags <= 3'b011;
               end else begin
                  out <= {sign_reg, e_c[EXP_W-1:0], frac_c};  flags <= {2'b00, inexact_reg};
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: if (!start) begin
               done <= 1'b0;  busy <= 1'b0;  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq (float32 configuration).
module tb_fpu_seq;
   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [1:0]  op;
   logic [31:0] in_a, in_b, out;
   logic        done, busy;
   logic [2:0]  flags;
   int          checks = 0;
   int          errors = 0;

   fpu_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .in_a(in_a), .in_b(in_b), .out(out), .done(done), .busy(busy), .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one request, scrambles inputs after acceptance, returns result and latency
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [2:0] f, output int edges,
                         output logic busy_ok);
      @(negedge clk);
      op = o;  in_a = a;  in_b = b;  start = 1'b1;
      @(posedge clk);  #1;
      in_a = 32'hFFFF_FFFF;  in_b = 32'hFFFF_FFFF;  op = 2'b11;
      busy_ok = busy;
      edges = 0;
      while (!done && edges < 200) begin
         @(posedge clk);  #1;
         edges++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      r = out;  f = flags;
      $display("op=%b a=%h b=%h -> out=%h flags=%b done_edge=%0d", o, a, b, r, f, edges);
      @(negedge clk);  start = 1'b0;
      @(posedge clk);  #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;  start = 1'b0;  op = 2'b00;  in_a = '0;  in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out, done, busy, flags} !== 37'd0) begin
         errors++;  $display("FAIL reset_hold: got out=%h done=%b busy=%b flags=%b, want all 0", out, done, busy, flags);
      end
      @(negedge clk);  rst_n = 1'b1;
      @(posedge clk);  #1;
      checks++;
      if ({out, done, busy, flags} !== 37'd0) begin
         errors++;  $display("FAIL reset_release: got out=%h done=%b busy=%b flags=%b, want all 0", out, done, busy, flags);
      end
      $display("reset: out=%h done=%b busy=%b flags=%b", out, done, busy, flags);
   endtask

   task automatic test_add();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      run_op(2'b00, 32'h3FC00000, 32'h40100000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h40700000, 3'b000}) begin
         errors++;  $display("FAIL add_1p5_2p25: got %h/%b, want 40700000/000", r, f);
      end
      checks++;
      if (e !== 5) begin errors++;  $display("FAIL add_latency: got %0d, want 5", e);  end
      checks++;
      if (bk !== 1'b1) begin errors++;  $display("FAIL add_busy: got %b, want 1", bk);  end
   endtask

   task automatic test_mul();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      run_op(2'b10, 32'h40400000, 32'hC0000000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'hC0C00000, 3'b000}) begin
         errors++;  $display("FAIL mul_3_m2: got %h/%b, want c0c00000/000", r, f);
      end
      checks++;
      if (e !== 28) begin errors++;  $display("FAIL mul_latency: got %0d, want 28", e);  end
      checks++;
      if (bk !== 1'b1) begin errors++;  $display("FAIL mul_busy: got %b, want 1", bk);  end
      run_op(2'b10, 32'h3FC00000, 32'h3FC00000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h40100000, 3'b000}) begin
         errors++;  $display("FAIL mul_carry: got %h/%b, want 40100000/000", r, f);
      end
      checks++;
      if (e !== 29) begin errors++;  $display("FAIL mul_carry_latency: got %0d, want 29", e);  end
   endtask

   task automatic test_sub();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      run_op(2'b01, 32'h3F800000, 32'h3F7FFFFF, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h33800000, 3'b000}) begin
         errors++;  $display("FAIL sub_cancel: got %h/%b, want 33800000/000", r, f);
      end
      checks++;
      if (e !== 28) begin errors++;  $display("FAIL sub_cancel_latency: got %0d, want 28", e);  end
      run_op(2'b01, 32'h3F800000, 32'h3F800000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h00000000, 3'b000}) begin
         errors++;  $display("FAIL sub_equal: got %h/%b, want 00000000/000", r, f);
      end
      checks++;
      if (e !== 3) begin errors++;  $display("FAIL sub_equal_latency: got %0d, want 3", e);  end
   endtask

   task automatic test_special();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      run_op(2'b10, 32'h7F7FFFFF, 32'h40000000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h7F800000, 3'b101}) begin
         errors++;  $display("FAIL mul_overflow: got %h/%b, want 7f800000/101", r, f);
      end
      run_op(2'b00, 32'h7F800000, 32'hFF800000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h7FC00000, 3'b000}) begin
         errors++;  $display("FAIL inf_minus_inf: got %h/%b, want 7fc00000/000", r, f);
      end
      checks++;
      if (e !== 2) begin errors++;  $display("FAIL special_latency: got %0d, want 2", e);  end
      run_op(2'b10, 32'h00000000, 32'hFF800000, r, f, e, bk);
      checks++;
      if (r !== 32'h7FC00000) begin errors++;  $display("FAIL zero_times_inf: got %h, want 7fc00000", r);  end
      run_op(2'b10, 32'h40000000, 32'h80000000, r, f, e, bk);
      checks++;
      if (r !== 32'h80000000) begin errors++;  $display("FAIL mul_neg_zero: got %h, want 80000000", r);  end
      run_op(2'b01, 32'h00000000, 32'h40000000, r, f, e, bk);
      checks++;
      if (r !== 32'hC0000000) begin errors++;  $display("FAIL zero_minus_b: got %h, want c0000000", r);  end
   endtask

   task automatic test_round();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      run_op(2'b00, 32'h3F800000, 32'h33800000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h3F800000, 3'b001}) begin
         errors++;  $display("FAIL round_tie_even_down: got %h/%b, want 3f800000/001", r, f);
      end
      run_op(2'b00, 32'h3F800001, 32'h33800000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h3F800002, 3'b001}) begin
         errors++;  $display("FAIL round_tie_even_up: got %h/%b, want 3f800002/001", r, f);
      end
   endtask

   task automatic test_handshake();
      int n;
      @(negedge clk);
      op = 2'b00;  in_a = 32'h3FC00000;  in_b = 32'h40100000;  start = 1'b1;
      n = 0;
      do begin @(posedge clk);  #1;  n++;  end while (!done && n < 100);
      checks++;
      if (done !== 1'b1) begin errors++;  $display("FAIL hs_done: got %b, want 1", done);  end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);  #1;
         checks++;
         if ({done, busy, out} !== {2'b11, 32'h40700000}) begin
            errors++;  $display("FAIL hs_hold[%0d]: got done=%b busy=%b out=%h, want 1 1 40700000", i, done, busy, out);
         end
      end
      @(negedge clk);  start = 1'b0;
      @(posedge clk);  #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;  $display("FAIL hs_release: got done=%b busy=%b, want 0 0", done, busy);
      end
      $display("handshake: held start 10 cycles, done=%b busy=%b after release", done, busy);
   endtask

   task automatic test_reset_abort();
      logic [31:0] r;  logic [2:0] f;  int e;  logic bk;
      @(negedge clk);
      op = 2'b10;  in_a = 32'h40400000;  in_b = 32'h40400000;  start = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;  start = 1'b0;
      #1;
      checks++;
      if ({out, done, busy, flags} !== 37'd0) begin
         errors++;  $display("FAIL abort_async: got out=%h done=%b busy=%b flags=%b, want all 0", out, done, busy, flags);
      end
      @(negedge clk);  rst_n = 1'b1;
      run_op(2'b00, 32'h3FC00000, 32'h40100000, r, f, e, bk);
      checks++;
      if ({r, f} !== {32'h40700000, 3'b000} || e !== 5) begin
         errors++;  $display("FAIL abort_recover: got %h/%b at edge %0d, want 40700000/000 at edge 5", r, f, e);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_sub();
      test_special();
      test_round();
      test_handshake();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
